// File: rtl/spi_cmd_log_iomem_pkg.sv
// Shared register map, log entry layout and bus FSM encoding for the SPI command logger.
package spi_cmd_log_iomem_pkg;

  localparam logic [7:0] RegCounter = 8'h00;
  localparam logic [7:0] RegStatus  = 8'h04;
  localparam logic [7:0] RegW0      = 8'h08;
  localparam logic [7:0] RegW1      = 8'h0C;
  localparam logic [7:0] RegW2      = 8'h10;
  localparam logic [7:0] RegDrops   = 8'h14;
  localparam logic [7:0] RegSr      = 8'h18;
  localparam logic [7:0] RegCtrl    = 8'h1C;

  localparam int unsigned TsW   = 24;
  localparam int unsigned CmdW  = 8;
  localparam int unsigned AddrW = 32;
  localparam int unsigned LenW  = 12;
  localparam int unsigned ChW   = 4;
  localparam int unsigned EntryW = TsW + CmdW + AddrW + LenW + ChW;

  localparam logic [31:0] BadReg    = 32'hDECAFBAD;
  localparam logic [31:0] EmptyWord = 32'hFFFFFFFF;

  typedef struct packed {
    logic [TsW-1:0]   ts;
    logic [CmdW-1:0]  cmd;
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
    logic [ChW-1:0]   ch;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StWait, StDone} bus_st_e;

  // Bus view of a log entry: 0 = {ts, cmd}, 1 = addr, 2 = {ch, len}.
  function automatic logic [31:0] entry_word(entry_t e, logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {e.ts, e.cmd};
      2'd1:    w = e.addr;
      default: w = {e.ch, 16'h0, e.len};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/spi_cmd_log_iomem_sync_fifo.sv
// Synchronous FIFO with registered read port so the storage maps onto block RAM.
module spi_cmd_log_iomem_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_16mhz,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned Aw   = $clog2(DEPTH);
  localparam int unsigned CntW = Aw + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_16mhz) begin
    if (!resetn || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    rdata_q <= mem_q[rd_ptr_q];
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/spi_cmd_log_iomem.sv
// Timestamped multi-channel SPI command log on the iomem bus, plus status-register override.
module spi_cmd_log_iomem
  import spi_cmd_log_iomem_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned TS_SHIFT = 4
) (
  input  logic                     clk_16mhz,
  input  logic                     resetn,
  input  logic [CHANNELS-1:0]      cmd_strobe_i,
  input  logic [8*CHANNELS-1:0]    cmd_i,
  input  logic [32*CHANNELS-1:0]   cmd_addr_i,
  input  logic [12*CHANNELS-1:0]   cmd_len_i,
  input  logic [7:0]               sr_in_i,
  output logic [7:0]               sr_out_o,
  output logic                     sr_strobe_o,
  output logic                     irq_o,
  input  logic                     sel_i,
  input  logic [7:0]               addr_i,
  input  logic [3:0]               wstrb_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     ready_o
);

  localparam int unsigned ChIdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;

  logic [27:0]         counter_q;
  logic [TsW-1:0]      ts;
  logic                enable_q;
  logic [7:0]          thresh_q;
  logic [15:0]         drops_q, drops_d;
  logic [16:0]         drops_sum;
  logic [3:0]          drop_cnt;
  logic [7:0]          sr_out_q;
  logic                sr_strobe_q;

  entry_t              hold_q [CHANNELS];
  logic [CHANNELS-1:0] hold_vld_q, load;
  logic [ChIdxW-1:0]   rr_q, grant_idx, cand;
  logic                grant_vld, push;

  entry_t              fifo_head;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_full, fifo_empty;

  bus_st_e             state_q, state_d;
  logic [7:0]          addr_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         wdata_q;
  logic                head_empty_q;
  logic                is_wr, do_pop, do_clr_drops, do_sr, do_ctrl, flush;

  assign ts    = counter_q[TS_SHIFT +: TsW];
  assign is_wr = |wstrb_q;
  assign flush = do_ctrl && wstrb_q[0] && wdata_q[1];
  assign irq_o = (thresh_q != 8'h0) && (32'(fifo_count) >= 32'(thresh_q));
  assign sr_out_o    = sr_out_q;
  assign sr_strobe_o = sr_strobe_q;

  // Round-robin: lowest offset from rr_q among full holding regs wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      cand = ChIdxW'((int'(rr_q) + off) % CHANNELS);
      if (hold_vld_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign push = grant_vld && !fifo_full && !flush;

  always_comb begin
    load     = '0;
    drop_cnt = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      load[ch] = cmd_strobe_i[ch] && enable_q && !hold_vld_q[ch] && !flush;
      if (cmd_strobe_i[ch] && enable_q && hold_vld_q[ch]) drop_cnt = drop_cnt + 4'd1;
    end
    drops_sum = {1'b0, drops_q} + 17'(drop_cnt);
    if (do_clr_drops) begin
      drops_d = '0;
    end else if (drops_sum[16]) begin
      drops_d = 16'hFFFF;
    end else begin
      drops_d = drops_sum[15:0];
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      hold_vld_q <= '0;
      rr_q       <= '0;
    end else if (flush) begin
      hold_vld_q <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (push && grant_idx == ChIdxW'(ch)) hold_vld_q[ch] <= 1'b0;
        if (load[ch]) hold_vld_q[ch] <= 1'b1;
      end
      if (push) begin
        rr_q <= (grant_idx == ChIdxW'(CHANNELS - 1)) ? '0 : grant_idx + ChIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_16mhz) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (load[ch]) begin
        hold_q[ch] <= '{ts:   ts,
                        cmd:  cmd_i[8*ch +: 8],
                        addr: cmd_addr_i[32*ch +: 32],
                        len:  cmd_len_i[12*ch +: 12],
                        ch:   ChW'(ch)};
      end
    end
  end

  spi_cmd_log_iomem_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_16mhz (clk_16mhz),
    .resetn    (resetn),
    .flush_i   (flush),
    .push_i    (push),
    .wdata_i   (hold_q[grant_idx]),
    .pop_i     (do_pop),
    .rdata_o   (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      counter_q   <= '0;
      enable_q    <= 1'b1;
      thresh_q    <= '0;
      drops_q     <= '0;
      sr_out_q    <= '0;
      sr_strobe_q <= 1'b0;
    end else begin
      counter_q   <= counter_q + 28'd1;
      drops_q     <= drops_d;
      sr_strobe_q <= do_sr;
      if (do_sr) sr_out_q <= wdata_q[7:0];
      if (do_ctrl && wstrb_q[0]) enable_q <= wdata_q[0];
      if (do_ctrl && wstrb_q[1]) thresh_q <= wdata_q[15:8];
    end
  end

  // Bus handshake: state register.
  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      head_empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && sel_i) begin
        addr_q  <= addr_i;
        wstrb_q <= wstrb_i;
        wdata_q <= wdata_i;
      end
      // Emptiness sampled alongside the RAM read so it matches the registered head.
      if (state_q == StWait) head_empty_q <= fifo_empty;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sel_i) state_d = StWait;
      StWait:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    rdata_o      = '0;
    do_pop       = 1'b0;
    do_clr_drops = 1'b0;
    do_sr        = 1'b0;
    do_ctrl      = 1'b0;
    if (state_q == StDone) begin
      ready_o = 1'b1;
      if (is_wr) begin
        do_clr_drops = (addr_q == RegDrops);
        do_sr        = (addr_q == RegSr) && wstrb_q[0];
        do_ctrl      = (addr_q == RegCtrl);
      end else begin
        case (addr_q)
          RegCounter: rdata_o = {4'h0, counter_q};
          RegStatus:  rdata_o = {16'(fifo_count), 15'h0, fifo_full};
          RegW0:      rdata_o = head_empty_q ? EmptyWord : entry_word(fifo_head, 2'd0);
          RegW1:      rdata_o = head_empty_q ? EmptyWord : entry_word(fifo_head, 2'd1);
          RegW2: begin
            rdata_o = head_empty_q ? EmptyWord : entry_word(fifo_head, 2'd2);
            do_pop  = !head_empty_q;
          end
          RegDrops:   rdata_o = {16'h0, drops_q};
          RegSr:      rdata_o = {24'h0, sr_in_i};
          RegCtrl:    rdata_o = {16'h0, thresh_q, 7'h0, enable_q};
          default:    rdata_o = BadReg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_log_iomem.sv
// Directed bench for the SPI command logger: two channels, four-entry log.
module tb_spi_cmd_log_iomem;

  localparam int unsigned Ch    = 2;
  localparam int unsigned Depth = 4;

  logic              clk_16mhz = 1'b0;
  logic              resetn    = 1'b0;
  logic [Ch-1:0]     cmd_strobe = '0;
  logic [8*Ch-1:0]   cmd        = '0;
  logic [32*Ch-1:0]  cmd_addr   = '0;
  logic [12*Ch-1:0]  cmd_len    = '0;
  logic [7:0]        sr_in      = '0;
  logic [7:0]        sr_out;
  logic              sr_strobe;
  logic              irq;
  logic              sel   = 1'b0;
  logic [7:0]        addr  = '0;
  logic [3:0]        wstrb = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          sr_pulses = 0;
  logic [7:0]  sr_seen = '0;
  logic [31:0] d, c1;
  int          p0, rdy_hits;

  spi_cmd_log_iomem #(
    .CHANNELS (Ch),
    .DEPTH    (Depth),
    .TS_SHIFT (4)
  ) dut (
    .clk_16mhz    (clk_16mhz),
    .resetn       (resetn),
    .cmd_strobe_i (cmd_strobe),
    .cmd_i        (cmd),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .sr_in_i      (sr_in),
    .sr_out_o     (sr_out),
    .sr_strobe_o  (sr_strobe),
    .irq_o        (irq),
    .sel_i        (sel),
    .addr_i       (addr),
    .wstrb_i      (wstrb),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .ready_o      (ready)
  );

  always #31 clk_16mhz = ~clk_16mhz;

  always @(negedge clk_16mhz) begin
    if (sr_strobe) begin
      sr_pulses = sr_pulses + 1;
      sr_seen   = sr_out;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd);
    bit got = 1'b0;
    rd = '0;
    @(negedge clk_16mhz);
    sel = 1'b1; addr = a; wstrb = ws; wdata = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_16mhz);
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    sel = 1'b0; wstrb = '0;
    check_eq("bus_ready", 32'(got), 32'd1);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
    bus(a, 4'h0, 32'h0, v);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd);
    logic [31:0] unused;
    bus(a, ws, wd, unused);
  endtask

  task automatic strobe(input int ch, input logic [7:0] c, input logic [31:0] a,
                        input logic [11:0] l);
    @(negedge clk_16mhz);
    cmd_strobe[ch] = 1'b1;
    cmd[8*ch +: 8] = c;
    cmd_addr[32*ch +: 32] = a;
    cmd_len[12*ch +: 12] = l;
    @(negedge clk_16mhz);
    cmd_strobe = '0;
    repeat (4) @(negedge clk_16mhz);
  endtask

  initial begin
    repeat (4) @(negedge clk_16mhz);
    resetn = 1'b1;
    @(negedge clk_16mhz);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_sr_out", 32'(sr_out), 32'h0);
    rd_reg(8'h04, d); check_eq("rst_status", d, 32'h0);
    rd_reg(8'h1C, d); check_eq("rst_ctrl", d, 32'h0000_0001);
    rd_reg(8'h14, d); check_eq("rst_drops", d, 32'h0);

    // 1: single command round trip
    strobe(0, 8'h03, 32'h0012_3456, 12'd64);
    rd_reg(8'h04, d); check_eq("t1_status", d, 32'h0001_0000);
    rd_reg(8'h08, d); check_eq("t1_w0_cmd", {24'h0, d[7:0]}, 32'h03);
    rd_reg(8'h0C, d); check_eq("t1_w1", d, 32'h0012_3456);
    rd_reg(8'h10, d); check_eq("t1_w2", d, 32'h0000_0040);
    rd_reg(8'h04, d); check_eq("t1_status_pop", d, 32'h0);

    // 2: simultaneous strobes; pointer sits at ch1 after the ch0 grant above
    @(negedge clk_16mhz);
    cmd_strobe = 2'b11;
    cmd        = {8'h3B, 8'h0B};
    cmd_addr   = {32'h0000_2000, 32'h0000_1000};
    cmd_len    = {12'h022, 12'h011};
    @(negedge clk_16mhz);
    cmd_strobe = '0;
    repeat (5) @(negedge clk_16mhz);
    rd_reg(8'h04, d); check_eq("t2_status", d, 32'h0002_0000);
    rd_reg(8'h0C, d); check_eq("t2_first_addr", d, 32'h0000_2000);
    rd_reg(8'h10, d); check_eq("t2_first_w2", d, 32'h1000_0022);
    rd_reg(8'h0C, d); check_eq("t2_second_addr", d, 32'h0000_1000);
    rd_reg(8'h10, d); check_eq("t2_second_w2", d, 32'h0000_0011);
    rd_reg(8'h14, d); check_eq("t2_drops", d, 32'h0);

    // 3: overflow: 4 in FIFO, 5th parked in holding reg, 6th dropped
    for (int i = 0; i < 6; i++) strobe(0, 8'(8'h20 + i), 32'(32'hA0 + i), 12'(i + 1));
    rd_reg(8'h04, d); check_eq("t3_status_full", d, 32'h0004_0001);
    rd_reg(8'h14, d); check_eq("t3_drops", d, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rd_reg(8'h08, d); check_eq("t3_drain_cmd", {24'h0, d[7:0]}, 32'(32'h20 + i));
      rd_reg(8'h10, d); check_eq("t3_drain_w2", d, 32'(i + 1));
    end
    rd_reg(8'h04, d); check_eq("t3_status_empty", d, 32'h0);

    // 4: threshold irq, flush, enable gate
    wr_reg(8'h1C, 4'b0011, 32'h0000_0301);
    rd_reg(8'h1C, d); check_eq("t4_ctrl", d, 32'h0000_0301);
    strobe(0, 8'h41, 32'h1, 12'd1);
    strobe(0, 8'h42, 32'h2, 12'd2);
    check_eq("t4_irq_below", 32'(irq), 32'd0);
    strobe(0, 8'h43, 32'h3, 12'd3);
    check_eq("t4_irq_at", 32'(irq), 32'd1);
    rd_reg(8'h10, d); check_eq("t4_pop_w2", d, 32'h0000_0001);
    @(negedge clk_16mhz);
    check_eq("t4_irq_after_pop", 32'(irq), 32'd0);
    wr_reg(8'h1C, 4'b0011, 32'h0000_0303);
    rd_reg(8'h04, d); check_eq("t4_flush_status", d, 32'h0);
    rd_reg(8'h14, d); check_eq("t4_flush_drops", d, 32'h1);
    rd_reg(8'h1C, d); check_eq("t4_flush_selfclr", d, 32'h0000_0301);
    wr_reg(8'h1C, 4'b0001, 32'h0000_0000);
    rd_reg(8'h1C, d); check_eq("t4_ctrl_dis", d, 32'h0000_0300);
    strobe(1, 8'h55, 32'h5, 12'd5);
    rd_reg(8'h04, d); check_eq("t4_disabled_status", d, 32'h0);
    rd_reg(8'h14, d); check_eq("t4_disabled_drops", d, 32'h1);
    wr_reg(8'h1C, 4'b0011, 32'h0000_0001);

    // 5: drops clear, status override, unmapped and empty reads
    wr_reg(8'h14, 4'hF, 32'h0);
    rd_reg(8'h14, d); check_eq("t5_drops_clr", d, 32'h0);
    p0 = sr_pulses;
    wr_reg(8'h18, 4'b0001, 32'h0000_005A);
    repeat (3) @(negedge clk_16mhz);
    check_eq("t5_sr_pulses", 32'(sr_pulses - p0), 32'd1);
    check_eq("t5_sr_seen", 32'(sr_seen), 32'h5A);
    p0 = sr_pulses;
    wr_reg(8'h18, 4'b0010, 32'h0000_00C3);
    repeat (3) @(negedge clk_16mhz);
    check_eq("t5_sr_no_pulse", 32'(sr_pulses - p0), 32'd0);
    check_eq("t5_sr_kept", 32'(sr_out), 32'h5A);
    sr_in = 8'hA5;
    rd_reg(8'h18, d); check_eq("t5_sr_in", d, 32'h0000_00A5);
    rd_reg(8'h40, d); check_eq("t5_unmapped", d, 32'hDECA_FBAD);
    rd_reg(8'h10, d); check_eq("t5_empty_w2", d, 32'hFFFF_FFFF);
    rd_reg(8'h04, d); check_eq("t5_empty_status", d, 32'h0);
    rd_reg(8'h00, c1);
    rd_reg(8'h00, d); check_eq("t5_counter_delta", d - c1, 32'd3);

    // 6: reset during an access
    strobe(0, 8'h66, 32'h6, 12'd6);
    wr_reg(8'h1C, 4'b0011, 32'h0000_0500);
    @(negedge clk_16mhz);
    sel = 1'b1; addr = 8'h1C; wstrb = 4'b0001; wdata = 32'h3;
    @(negedge clk_16mhz);
    resetn   = 1'b0;
    rdy_hits = 0;
    repeat (3) begin
      @(negedge clk_16mhz);
      if (ready) rdy_hits++;
    end
    sel = 1'b0; wstrb = '0;
    resetn = 1'b1;
    @(negedge clk_16mhz);
    check_eq("t6_ready_held", 32'(rdy_hits), 32'd0);
    check_eq("t6_sr_out", 32'(sr_out), 32'h0);
    check_eq("t6_irq", 32'(irq), 32'd0);
    rd_reg(8'h1C, d); check_eq("t6_ctrl", d, 32'h0000_0001);
    rd_reg(8'h04, d); check_eq("t6_status", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
